// File: rtl/bounce_pkg.sv
// Shared types and the bounce step function for the bounce-count checker.
// The sample width lives here because next_step is typed on it.
package bounce_pkg;
  localparam int WIDTH = 4;
  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    dir_e             dir;
  } step_t;

  // Successor of v when travelling in direction d; turns at MAX and 0.
  function automatic step_t next_step(input logic [WIDTH-1:0] v, input dir_e d);
    step_t s;
    if (d == DIR_UP) begin
      if (v == MAX) begin s.value = MAX - 1'b1; s.dir = DIR_DOWN; end
      else          begin s.value = v + 1'b1;   s.dir = DIR_UP;   end
    end else begin
      if (v == '0)  begin s.value = 1;          s.dir = DIR_UP;   end
      else          begin s.value = v - 1'b1;   s.dir = DIR_DOWN; end
    end
    return s;
  endfunction
endpackage

// File: rtl/bounce_seq_checker.sv
// Receive-side checker for the up/down bounce count stream.
// Locks after LOCK_CNT correct steps, flywheels the prediction through
// mismatches and drops lock after MISS_LIM consecutive misses.
// Optional idle-timeout lock drop: define BOUNCE_CHK_TIMEOUT_EN.
module bounce_seq_checker
  import bounce_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int MISS_LIM = 2,
  parameter int ERR_W    = 8
`ifdef BOUNCE_CHK_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             locked,
  output logic             dir,
  output logic [WIDTH-1:0] expected,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic             timeout
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int SW = $clog2(MISS_LIM + 1);

  state_e           state;
  logic [WIDTH-1:0] prev;
  dir_e             acq_dir;
  logic [MW-1:0]    match;
  logic [SW-1:0]    miss;
`ifdef BOUNCE_CHK_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0]    idle;
`endif

  logic  step_up, step_dn, acq_hit;
  dir_e  step_dir;
  step_t nx_prev, nx_lock, nx_exp;

  // Step classification during acquisition and the three successor predictions.
  always_comb begin
    step_up  = (prev != MAX) && (data == prev + 1'b1);
    step_dn  = (prev != '0)  && (data == prev - 1'b1);
    nx_prev  = next_step(prev, acq_dir);
    step_dir = (match == '0) ? (step_up ? DIR_UP : DIR_DOWN) : nx_prev.dir;
    acq_hit  = (match == '0) ? (step_up || step_dn) : (data == nx_prev.value);
    nx_lock  = next_step(data, step_dir);
    nx_exp   = next_step(expected, dir_e'(dir));
  end

  // State, tracking counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      prev      <= '0;
      acq_dir   <= DIR_UP;
      match     <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      dir       <= 1'b0;
      expected  <= '0;
      error     <= 1'b0;
      err_count <= '0;
      timeout   <= 1'b0;
`ifdef BOUNCE_CHK_TIMEOUT_EN
      idle      <= '0;
`endif
    end else begin
      error   <= 1'b0;
      timeout <= 1'b0;
      if (valid) begin
        case (state)
          SEARCH: begin
            prev  <= data;
            match <= '0;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            prev <= data;
            if (acq_hit) begin
              acq_dir <= step_dir;
              if (match == MW'(LOCK_CNT - 1)) begin
                match    <= '0;
                miss     <= '0;
                state    <= LOCKED;
                locked   <= 1'b1;
                expected <= nx_lock.value;
                dir      <= nx_lock.dir;
              end else begin
                match <= match + 1'b1;
              end
            end else begin
              match <= '0;
            end
          end
          LOCKED: begin
            // Prediction advances on hit and miss alike.
            expected <= nx_exp.value;
            dir      <= nx_exp.dir;
            if (data == expected) begin
              miss <= '0;
            end else begin
              error <= 1'b1;
              if (!(&err_count)) err_count <= err_count + 1'b1;
              if (miss == SW'(MISS_LIM - 1)) begin
                miss   <= '0;
                state  <= SEARCH;
                locked <= 1'b0;
              end else begin
                miss <= miss + 1'b1;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
`ifdef BOUNCE_CHK_TIMEOUT_EN
      // Idle watchdog: only counts while locked, any valid sample restarts it.
      if (valid) begin
        idle <= '0;
      end else if (state == LOCKED) begin
        if (idle == IW'(TIMEOUT - 1)) begin
          idle    <= '0;
          state   <= SEARCH;
          locked  <= 1'b0;
          timeout <= 1'b1;
        end else begin
          idle <= idle + 1'b1;
        end
      end
`endif
      // Clear wins over a same-cycle increment.
      if (clear) err_count <= '0;
    end
  end
endmodule

// File: tb/tb_bounce_seq_checker.sv
// Self-checking bench for bounce_seq_checker: directed scenarios plus random
// stimulus against a phase-based model of the bounce sequence.
module tb_bounce_seq_checker;
  localparam int MX       = 15;
  localparam int PER      = 2 * MX;
  localparam int LOCK_CNT = 3;
  localparam int MISS_LIM = 2;
  localparam int TOUT     = 16;

  logic       clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clear = 1'b0;
  logic [3:0] data = '0;
  logic       locked, dir, error, timeout;
  logic [3:0] expected;
  logic [7:0] err_count;

  bounce_seq_checker dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .data(data), .clear(clear),
    .locked(locked), .dir(dir), .expected(expected), .error(error),
    .err_count(err_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Model: the sequence is a cycle of PER phases; phase p shows value val(p)
  // and was reached by a step in direction pdir(p).
  int m_st, ph, miss, idle, m_locked, m_exp, m_dir, m_err, m_cnt, m_to;
  int run[$];

  function automatic int val(input int p);
    return (p <= MX) ? p : PER - p;
  endfunction

  function automatic int pdir(input int p);
    return (p >= 1 && p <= MX) ? 0 : 1;
  endfunction

  // Does x extend the current candidate run as a legal bounce step?
  function automatic bit fits(input int x);
    int a, s, t;
    if (run.size() == 0) return 0;
    a = run[run.size()-1];
    s = x - a;
    if (s != 1 && s != -1) return 0;
    if (run.size() == 1) return 1;
    t = a - run[run.size()-2];
    return (s == t) || (a == MX && t == 1 && s == -1) || (a == 0 && t == -1 && s == 1);
  endfunction

  task automatic model_reset();
    m_st = 0; ph = 0; miss = 0; idle = 0; m_locked = 0;
    m_exp = 0; m_dir = 0; m_err = 0; m_cnt = 0; m_to = 0;
    run.delete();
  endtask

  task automatic model_clk(input bit v, input int x, input bit c);
    int p;
    m_err = 0; m_to = 0;
    if (v) begin
      idle = 0;
      case (m_st)
        0: begin run.delete(); run.push_back(x); m_st = 1; end
        1: begin
          if (fits(x)) begin
            run.push_back(x);
            if (run.size() == LOCK_CNT + 1) begin
              p = (x > run[run.size()-2]) ? x : (PER - x) % PER;
              ph = (p + 1) % PER;
              m_exp = val(ph); m_dir = pdir(ph);
              m_locked = 1; m_st = 2; miss = 0;
            end
          end else begin
            run.delete(); run.push_back(x);
          end
        end
        default: begin
          if (x != m_exp) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
            miss++;
          end else miss = 0;
          ph = (ph + 1) % PER;
          m_exp = val(ph); m_dir = pdir(ph);
          if (miss == MISS_LIM) begin m_st = 0; m_locked = 0; miss = 0; end
        end
      endcase
    end else if (m_st == 2) begin
`ifdef BOUNCE_CHK_TIMEOUT_EN
      idle++;
      if (idle == TOUT) begin m_to = 1; m_st = 0; m_locked = 0; idle = 0; end
`endif
    end
    if (c) m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".locked"},    32'(locked),    m_locked);
    chk({tag, ".dir"},       32'(dir),       m_dir);
    chk({tag, ".expected"},  32'(expected),  m_exp);
    chk({tag, ".error"},     32'(error),     m_err);
    chk({tag, ".err_count"}, 32'(err_count), m_cnt);
    chk({tag, ".timeout"},   32'(timeout),   m_to);
  endtask

  task automatic step(input bit v, input int x, input bit c, input string tag);
    @(negedge clk);
    valid = v; data = 4'(x); clear = c;
    @(posedge clk);
    model_clk(v, x, c);
    #1 check_all(tag);
  endtask

  task automatic feed(input int x);
    step(1'b1, x, 1'b0, "seq");
  endtask

  initial begin
    bit saw_to;
    int gph;
    bit v, c;
    int x;
    model_reset();
    #12 check_all("rst");
    @(negedge clk) rst_n = 1'b1;

    // Lock on 0,1,2,3
    foreach (run[i]) ; // no-op: keeps queue type exercised before use
    for (int i = 0; i <= 3; i++) feed(i);
    chk("lock.locked", 32'(locked), 1);
    chk("lock.expected", 32'(expected), 4);
    chk("lock.dir", 32'(dir), 0);
    chk("lock.error", 32'(error), 0);

    // Top turn
    for (int i = 4; i <= 15; i++) feed(i);
    chk("top.expected", 32'(expected), 14);
    chk("top.dir", 32'(dir), 1);
    feed(14);
    chk("top2.expected", 32'(expected), 13);
    chk("top2.error", 32'(error), 0);

    // Bottom turn
    for (int i = 13; i >= 0; i--) feed(i);
    chk("bot.dir", 32'(dir), 0);
    chk("bot.expected", 32'(expected), 1);
    feed(1);
    chk("bot2.expected", 32'(expected), 2);

    // Miss and relock
    feed(2); feed(3); feed(4);
    chk("pre.expected", 32'(expected), 5);
    feed(9);
    chk("miss.error", 32'(error), 1);
    chk("miss.err_count", 32'(err_count), 1);
    chk("miss.expected", 32'(expected), 6);
    chk("miss.locked", 32'(locked), 1);
    feed(6);
    chk("hit.error", 32'(error), 0);
    feed(0); feed(0);
    chk("drop.err_count", 32'(err_count), 3);
    chk("drop.locked", 32'(locked), 0);
    feed(4); feed(3); feed(2); feed(1);
    chk("relock.locked", 32'(locked), 1);
    chk("relock.dir", 32'(dir), 1);
    chk("relock.expected", 32'(expected), 0);

    // Clear colliding with a mismatch
    step(1'b1, 7, 1'b1, "clr");
    chk("clr.err_count", 32'(err_count), 0);
    chk("clr.error", 32'(error), 1);

    // Saturate the error counter with alternating hit/miss
    for (int i = 0; i < 600 && m_cnt < 255; i++) begin
      feed(m_exp);
      feed((m_exp + 1) % 16);
    end
    chk("sat.err_count", 32'(err_count), 255);
    feed(m_exp);
    feed((m_exp + 1) % 16);
    chk("sat2.err_count", 32'(err_count), 255);
    chk("sat2.error", 32'(error), 1);

    // Asynchronous reset between clock edges
    feed(m_exp);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("arst");
    @(negedge clk) rst_n = 1'b1;
    feed(5);
    chk("arst.search", 32'(locked), 0);
    feed(6); feed(7); feed(8);
    chk("arst.relock", 32'(expected), 9);

    // Idle hold for the timeout window
    saw_to = 0;
    for (int i = 0; i < TOUT; i++) begin
      step(1'b0, 0, 1'b0, "idle");
      if (timeout) saw_to = 1;
    end
`ifdef BOUNCE_CHK_TIMEOUT_EN
    chk("to.pulse", 32'(saw_to), 1);
    chk("to.locked", 32'(locked), 0);
`else
    chk("to.pulse", 32'(saw_to), 0);
    chk("to.locked", 32'(locked), 1);
`endif
    step(1'b0, 0, 1'b0, "idle2");

    // Random mostly-correct stream with noise, gaps and clears
    gph = $urandom_range(0, PER - 1);
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) begin
        for (int k = 0; k < 20; k++) step(1'b0, 0, 1'b0, "rgap");
      end
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 31) == 0);
      x = ($urandom_range(0, 99) < 85) ? val(gph) : int'($urandom_range(0, 15));
      if (v) gph = (gph + 1) % PER;
      step(v, x, c, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
